otter_pc_ras: RTL and testbench
===============================

# otter_pc_ras

Parametrised program counter for the Otter fetch stage with configurable width, reset vector and an integrated return-address stack (RAS). Holds the current fetch address, presents the sequential successor, and selects the next address from trap, redirect, RAS-predicted return or datapath target under a fixed priority. Sits between the next-PC mux logic and instruction memory, replacing the fixed 32-bit PC register.

## Interface
- `XLEN`, 32: address width in bits.
- `RESET_VECTOR`, 0: value loaded into `addr` on reset.
- `INC`, 4: byte increment for `addr_inc`.
- `RAS_DEPTH`, 4: RAS entries; power of two, ≥2.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `w_en`  in  1  advance enable; 0 = stall.
- `next_addr`  in  XLEN  datapath-computed next address.
- `trap_valid`  in  1  trap/interrupt entry request.
- `trap_addr`  in  XLEN  trap vector target.
- `redirect_valid`  in  1  mispredict correction from execute.
- `redirect_addr`  in  XLEN  corrected target.
- `ras_push`  in  1  current instruction is a call; push `addr_inc`.
- `ras_pop`  in  1  current instruction is a return; use RAS top.
- `ras_flush`  in  1  clear RAS.
- `addr`  out  XLEN  current PC (register).
- `addr_inc`  out  XLEN  `addr + INC`, combinational, mod 2^XLEN.
- `ras_count`  out  $clog2(RAS_DEPTH)+1  valid entries.
- `ras_empty`, `ras_full`  out  1  count == 0 / count == RAS_DEPTH.

## Operation
- Next-PC priority per cycle: `rst` > `trap_valid` > `redirect_valid` > (`w_en` && `ras_pop` && !`ras_empty`: RAS top) > `w_en`: `next_addr` > hold.
- Trap and redirect load regardless of `w_en`; neither pushes nor pops the RAS.
- RAS updates only when `w_en`=1 and neither trap nor redirect is active that cycle.
- Push only: write `addr_inc` at top, count+1. Push when full: overwrite oldest entry (circular), count stays `RAS_DEPTH`.
- Pop only: count−1; empty pop is a no-op on RAS and PC takes `next_addr`.
- Push+pop same cycle (coroutine jump): PC takes old top (if non-empty, else `next_addr`); top replaced with `addr_inc`; count unchanged (empty: becomes 1).
- `ras_flush`: count → 0 next edge; overrides push/pop; PC selection that cycle still uses pre-flush top.
- All address arithmetic wraps modulo 2^XLEN; no alignment checking.

## Timing
- Reset: `addr`=`RESET_VECTOR`, `ras_count`=0, `ras_empty`=1, `ras_full`=0; entry contents don't-care.
- `addr` changes one cycle after the selecting input is sampled; `addr_inc` and flags follow `addr`/count combinationally.
- RAS top read is combinational from registered state; a push is visible to a pop in the following cycle.
- Reset mid-sequence discards all RAS contents and any pending redirect.

## Structure
- Shared `otter_defines.vh`: default `RESET_VECTOR` and `INC` constants for reuse by fetch/trap logic.
- Sub-module `otter_ras`: circular stack (pointer, count, storage, push/pop/flush); `otter_pc_ras` holds PC register and priority mux.

## Test plan
- Reset with `RESET_VECTOR`=0x100 → `addr`=0x100, `addr_inc`=0x104, `ras_empty`=1.
- `w_en`=1, `next_addr`=0x200, `ras_push`=1 at addr 0x100 → `addr`=0x200, top=0x104, count=1; then `ras_pop`=1, `next_addr`=0xDEAD → `addr`=0x104, count=0.
- Five pushes with `RAS_DEPTH`=4 → count=4, `ras_full`=1; four pops return last four `addr_inc` values LIFO; fifth pop empty → PC=`next_addr`.
- `trap_valid`+`redirect_valid`+`ras_pop` with `w_en`=0 → `addr`=`trap_addr`, count unchanged.
- Push+pop together with top=0x40 at addr 0x80 → `addr`=0x40, top=0x84, count unchanged; `addr`=0xFFFFFFFC → `addr_inc`=0.

Source files
------------

// File: rtl/otter_pc_ras_pkg.sv
// Shared constants and types for the Otter fetch-stage PC with return-address stack.
package otter_pc_ras_pkg;

  localparam int unsigned DEF_XLEN         = 32;
  localparam int unsigned DEF_RESET_VECTOR = 32'h0000_0000;
  localparam int unsigned DEF_INC          = 4;
  localparam int unsigned DEF_RAS_DEPTH    = 4;

  // Next-PC source, listed from lowest to highest priority
  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_NEXT,
    SEL_RAS,
    SEL_REDIR,
    SEL_TRAP
  } pc_sel_e;

endpackage

// File: rtl/otter_pc_ras_if.sv
// Fetch-control <-> PC bundle: next-PC requests, RAS controls and PC/RAS status.
interface otter_pc_ras_if
  import otter_pc_ras_pkg::*;
#(
  parameter int unsigned XLEN      = DEF_XLEN,
  parameter int unsigned RAS_DEPTH = DEF_RAS_DEPTH
);
  localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

  logic            w_en;
  logic [XLEN-1:0] next_addr;
  logic            trap_valid;
  logic [XLEN-1:0] trap_addr;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_addr;
  logic            ras_push;
  logic            ras_pop;
  logic            ras_flush;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] addr_inc;
  logic [CW-1:0]   ras_count;
  logic            ras_empty;
  logic            ras_full;

  modport master (
    output w_en, next_addr, trap_valid, trap_addr, redirect_valid, redirect_addr,
           ras_push, ras_pop, ras_flush,
    input  addr, addr_inc, ras_count, ras_empty, ras_full
  );

  modport slave (
    input  w_en, next_addr, trap_valid, trap_addr, redirect_valid, redirect_addr,
           ras_push, ras_pop, ras_flush,
    output addr, addr_inc, ras_count, ras_empty, ras_full
  );

endinterface

// File: rtl/otter_ras.sv
// Circular return-address stack: a full push overwrites the oldest entry.
module otter_ras
  import otter_pc_ras_pkg::*;
#(
  parameter int unsigned XLEN      = DEF_XLEN,
  parameter int unsigned RAS_DEPTH = DEF_RAS_DEPTH,
  localparam int unsigned PW = $clog2(RAS_DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic [CW-1:0]   count
);

  logic [XLEN-1:0] mem_q [RAS_DEPTH];
  logic [XLEN-1:0] mem_d [RAS_DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // ptr_q always indexes the top entry; when full, ptr_q+1 is the oldest
  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          ptr_d        = ptr_q + PW'(1);
          mem_d[ptr_d] = push_data;
          if (cnt_q != CW'(RAS_DEPTH)) cnt_d = cnt_q + CW'(1);
        end
        2'b01: begin
          if (cnt_q != '0) begin
            ptr_d = ptr_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
          end
        end
        2'b11: begin
          mem_d[ptr_q] = push_data;
          if (cnt_q == '0) cnt_d = CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry contents need no reset; count alone decides validity
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign top   = mem_q[ptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/otter_pc_ras.sv
// Fetch PC register with fixed-priority next-address selection and an integrated RAS.
module otter_pc_ras
  import otter_pc_ras_pkg::*;
#(
  parameter int unsigned     XLEN         = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter int unsigned     INC          = DEF_INC,
  parameter int unsigned     RAS_DEPTH    = DEF_RAS_DEPTH
) (
  input  logic           clk,
  input  logic           rst,
  otter_pc_ras_if.slave  bus
);

  localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] addr_inc;
  logic [XLEN-1:0] ras_top;
  logic [CW-1:0]   ras_count;
  logic            ras_empty;
  logic            ras_upd;
  pc_sel_e         sel;

  assign addr_inc  = addr_q + XLEN'(INC);
  assign ras_empty = (ras_count == '0);

  // Trap and redirect own the cycle: the RAS must not move under them
  assign ras_upd = bus.w_en && !bus.trap_valid && !bus.redirect_valid;

  always_comb begin
    sel = SEL_HOLD;
    if (bus.trap_valid)                           sel = SEL_TRAP;
    else if (bus.redirect_valid)                  sel = SEL_REDIR;
    else if (bus.w_en && bus.ras_pop && !ras_empty) sel = SEL_RAS;
    else if (bus.w_en)                            sel = SEL_NEXT;

    addr_d = addr_q;
    unique case (sel)
      SEL_TRAP:  addr_d = bus.trap_addr;
      SEL_REDIR: addr_d = bus.redirect_addr;
      SEL_RAS:   addr_d = ras_top;
      SEL_NEXT:  addr_d = bus.next_addr;
      default:   addr_d = addr_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) addr_q <= RESET_VECTOR;
    else     addr_q <= addr_d;
  end

  otter_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_upd && bus.ras_push),
    .pop       (ras_upd && bus.ras_pop),
    .flush     (bus.ras_flush),
    .push_data (addr_inc),
    .top       (ras_top),
    .count     (ras_count)
  );

  assign bus.addr      = addr_q;
  assign bus.addr_inc  = addr_inc;
  assign bus.ras_count = ras_count;
  assign bus.ras_empty = ras_empty;
  assign bus.ras_full  = (ras_count == CW'(RAS_DEPTH));

endmodule

// File: tb/tb_otter_pc_ras.sv
// Directed + randomized checks of otter_pc_ras against a queue-based reference model.
module tb_otter_pc_ras;
  import otter_pc_ras_pkg::*;

  localparam int unsigned    D  = 4;
  localparam logic [31:0]    RV = 32'h100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  otter_pc_ras_if #(.XLEN(32), .RAS_DEPTH(D)) bus ();

  otter_pc_ras #(.XLEN(32), .RESET_VECTOR(RV), .INC(4), .RAS_DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: PC value plus a bounded LIFO of return addresses (back = top)
  logic [31:0] m_pc;
  logic [31:0] mq[$];

  task automatic model_update();
    logic [31:0] inc;
    inc = m_pc + 32'd4;
    if (rst) begin
      m_pc = RV;
      mq.delete();
    end else if (bus.trap_valid) begin
      m_pc = bus.trap_addr;
      if (bus.ras_flush) mq.delete();
    end else if (bus.redirect_valid) begin
      m_pc = bus.redirect_addr;
      if (bus.ras_flush) mq.delete();
    end else if (bus.w_en) begin
      m_pc = (bus.ras_pop && mq.size() > 0) ? mq[$] : bus.next_addr;
      if (bus.ras_flush) mq.delete();
      else if (bus.ras_push && bus.ras_pop) begin
        if (mq.size() > 0) mq[$] = inc;
        else mq.push_back(inc);
      end else if (bus.ras_push) begin
        mq.push_back(inc);
        if (mq.size() > D) void'(mq.pop_front());
      end else if (bus.ras_pop && mq.size() > 0) begin
        void'(mq.pop_back());
      end
    end else if (bus.ras_flush) begin
      mq.delete();
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.w_en = 0; bus.next_addr = '0; bus.trap_valid = 0; bus.trap_addr = '0;
    bus.redirect_valid = 0; bus.redirect_addr = '0;
    bus.ras_push = 0; bus.ras_pop = 0; bus.ras_flush = 0;
  endtask

  task automatic drv(input bit w, input logic [31:0] na, input bit pu, input bit po, input bit fl);
    idle();
    bus.w_en = w; bus.next_addr = na; bus.ras_push = pu; bus.ras_pop = po; bus.ras_flush = fl;
  endtask

  task automatic test_reset();
    idle(); rst = 1; step(); rst = 0;
    total++; if (bus.addr !== 32'h100) begin bad++; $display("FAIL reset_addr got=%h exp=%h", bus.addr, 32'h100); end
    total++; if (bus.addr_inc !== 32'h104) begin bad++; $display("FAIL reset_addr_inc got=%h exp=%h", bus.addr_inc, 32'h104); end
    total++; if (bus.ras_empty !== 1'b1 || bus.ras_full !== 1'b0 || bus.ras_count !== 3'd0)
      begin bad++; $display("FAIL reset_flags got cnt=%0d e=%b f=%b exp cnt=0 e=1 f=0", bus.ras_count, bus.ras_empty, bus.ras_full); end
  endtask

  task automatic test_call_return();
    drv(1, 32'h200, 1, 0, 0); step();
    total++; if (bus.addr !== 32'h200 || bus.ras_count !== 3'd1)
      begin bad++; $display("FAIL call got addr=%h cnt=%0d exp addr=200 cnt=1", bus.addr, bus.ras_count); end
    drv(1, 32'hDEAD, 0, 1, 0); step();
    total++; if (bus.addr !== 32'h104 || bus.ras_count !== 3'd0)
      begin bad++; $display("FAIL return got addr=%h cnt=%0d exp addr=104 cnt=0", bus.addr, bus.ras_count); end
  endtask

  task automatic test_overflow();
    logic [31:0] a, exp;
    drv(1, 32'h1000, 0, 0, 1); step();
    for (int i = 0; i < 5; i++) begin
      a = 32'h1000 + 32'h100 * i;
      drv(1, a + 32'h100, 1, 0, 0); step();
      total++; if (bus.ras_count !== 3'((i + 1 > 4) ? 4 : i + 1) || bus.ras_full !== (i >= 3))
        begin bad++; $display("FAIL overflow_push%0d got cnt=%0d full=%b exp cnt=%0d full=%b", i, bus.ras_count, bus.ras_full, (i + 1 > 4) ? 4 : i + 1, i >= 3); end
    end
    for (int i = 4; i >= 1; i--) begin
      exp = 32'h1000 + 32'h100 * i + 32'd4;
      drv(1, 32'hBAD0, 0, 1, 0); step();
      total++; if (bus.addr !== exp)
        begin bad++; $display("FAIL overflow_pop%0d got=%h exp=%h", i, bus.addr, exp); end
    end
    drv(1, 32'hABC, 0, 1, 0); step();
    total++; if (bus.addr !== 32'hABC || bus.ras_empty !== 1'b1)
      begin bad++; $display("FAIL empty_pop got addr=%h e=%b exp addr=abc e=1", bus.addr, bus.ras_empty); end
  endtask

  task automatic test_trap_priority();
    drv(1, 32'h300, 0, 0, 1); step();
    drv(1, 32'h400, 1, 0, 0); step();
    drv(0, 32'h500, 0, 1, 0);
    bus.trap_valid = 1; bus.trap_addr = 32'h8000; bus.redirect_valid = 1; bus.redirect_addr = 32'h9000;
    step();
    total++; if (bus.addr !== 32'h8000 || bus.ras_count !== 3'd1)
      begin bad++; $display("FAIL trap_prio got addr=%h cnt=%0d exp addr=8000 cnt=1", bus.addr, bus.ras_count); end
    drv(1, 32'h500, 1, 1, 0); bus.redirect_valid = 1; bus.redirect_addr = 32'h9000; step();
    total++; if (bus.addr !== 32'h9000 || bus.ras_count !== 3'd1)
      begin bad++; $display("FAIL redirect got addr=%h cnt=%0d exp addr=9000 cnt=1", bus.addr, bus.ras_count); end
    drv(0, 32'h500, 0, 1, 0); step();
    total++; if (bus.addr !== 32'h9000 || bus.ras_count !== 3'd1)
      begin bad++; $display("FAIL stall got addr=%h cnt=%0d exp addr=9000 cnt=1", bus.addr, bus.ras_count); end
    drv(1, 32'h500, 0, 1, 0); step();
    total++; if (bus.addr !== 32'h304 || bus.ras_count !== 3'd0)
      begin bad++; $display("FAIL trap_then_pop got addr=%h cnt=%0d exp addr=304 cnt=0", bus.addr, bus.ras_count); end
  endtask

  task automatic test_coroutine();
    drv(1, 32'h3C, 0, 0, 1); step();
    drv(1, 32'h80, 1, 0, 0); step();
    drv(1, 32'h999, 1, 1, 0); step();
    total++; if (bus.addr !== 32'h40 || bus.ras_count !== 3'd1)
      begin bad++; $display("FAIL coroutine got addr=%h cnt=%0d exp addr=40 cnt=1", bus.addr, bus.ras_count); end
    drv(1, 32'h777, 0, 1, 0); step();
    total++; if (bus.addr !== 32'h84 || bus.ras_count !== 3'd0)
      begin bad++; $display("FAIL coroutine_top got addr=%h cnt=%0d exp addr=84 cnt=0", bus.addr, bus.ras_count); end
    drv(1, 32'h500, 1, 1, 0); step();
    total++; if (bus.addr !== 32'h500 || bus.ras_count !== 3'd1)
      begin bad++; $display("FAIL coroutine_empty got addr=%h cnt=%0d exp addr=500 cnt=1", bus.addr, bus.ras_count); end
    drv(1, 32'h600, 0, 1, 1); step();
    total++; if (bus.addr !== 32'h88 || bus.ras_count !== 3'd0)
      begin bad++; $display("FAIL flush_pop got addr=%h cnt=%0d exp addr=88 cnt=0", bus.addr, bus.ras_count); end
  endtask

  task automatic test_wrap();
    drv(0, 32'h0, 0, 0, 0); bus.redirect_valid = 1; bus.redirect_addr = 32'hFFFF_FFFC; step();
    total++; if (bus.addr_inc !== 32'h0)
      begin bad++; $display("FAIL wrap_inc got=%h exp=00000000", bus.addr_inc); end
    drv(1, 32'h10, 1, 0, 0); step();
    drv(1, 32'h20, 0, 1, 0); step();
    total++; if (bus.addr !== 32'h0)
      begin bad++; $display("FAIL wrap_ret got=%h exp=00000000", bus.addr); end
  endtask

  task automatic test_reset_mid();
    drv(1, 32'h2000, 1, 0, 0); step();
    drv(1, 32'h3000, 1, 0, 0); step();
    drv(1, 32'h4000, 1, 1, 0); bus.redirect_valid = 1; bus.redirect_addr = 32'h5000;
    rst = 1; step(); rst = 0;
    total++; if (bus.addr !== RV || bus.ras_count !== 3'd0 || bus.ras_empty !== 1'b1)
      begin bad++; $display("FAIL reset_mid got addr=%h cnt=%0d exp addr=%h cnt=0", bus.addr, bus.ras_count, RV); end
    drv(1, 32'h55, 0, 1, 0); step();
    total++; if (bus.addr !== 32'h55)
      begin bad++; $display("FAIL reset_mid_pop got=%h exp=00000055", bus.addr); end
  endtask

  task automatic test_random();
    logic [31:0] ra;
    for (int n = 0; n < 400; n++) begin
      idle();
      rst = ($urandom_range(63) == 0);
      bus.w_en = ($urandom_range(3) != 0);
      ra = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : $urandom;
      bus.next_addr = ra;
      bus.trap_valid = ($urandom_range(15) == 0); bus.trap_addr = $urandom;
      bus.redirect_valid = ($urandom_range(15) == 0); bus.redirect_addr = $urandom;
      bus.ras_push = ($urandom_range(2) == 0);
      bus.ras_pop = ($urandom_range(2) == 0);
      bus.ras_flush = bus.w_en && !bus.trap_valid && !bus.redirect_valid && ($urandom_range(31) == 0);
      step();
      rst = 0;
      total++; if (bus.addr !== m_pc)
        begin bad++; $display("FAIL rand_addr[%0d] got=%h exp=%h", n, bus.addr, m_pc); end
      total++; if (bus.addr_inc !== m_pc + 32'd4)
        begin bad++; $display("FAIL rand_inc[%0d] got=%h exp=%h", n, bus.addr_inc, m_pc + 32'd4); end
      total++; if (bus.ras_count !== 3'(mq.size()))
        begin bad++; $display("FAIL rand_cnt[%0d] got=%0d exp=%0d", n, bus.ras_count, mq.size()); end
      total++; if (bus.ras_empty !== (mq.size() == 0) || bus.ras_full !== (mq.size() == D))
        begin bad++; $display("FAIL rand_flags[%0d] got e=%b f=%b exp e=%b f=%b", n, bus.ras_empty, bus.ras_full, mq.size() == 0, mq.size() == D); end
    end
  endtask

  initial begin
    m_pc = '0;
    idle();
    test_reset();
    test_call_return();
    test_overflow();
    test_trap_priority();
    test_coroutine();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
